// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter that picks up to N_CDB completed results per cycle from
// N_REQ functional units and broadcasts them on the common data bus one cycle
// later. Scanning starts at rr_ptr and wraps. The j-th winner in scan order
// lands in CDB slot j, so slots fill lowest-first with no gaps.
//
// Optional feature: define CDB_ARBITER_PERF_EN to build the saturating
// arbitration-loss counter behind stall_cnt_o. Without it stall_cnt_o is tied
// to zero and no counter register exists.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   flush_i        pipeline flush; suppresses this cycle's grants
//   req_valid_i    per-requester "result available"
//   req_rob_id_i   per-requester ROB id          (N_REQ x RW)
//   req_pd_i       per-requester physical dest   (N_REQ x PW)
//   req_data_i     per-requester result value    (N_REQ x 32)
//   req_ready_o    per-requester "accepted this cycle" (combinational)
//   cdb_valid_o    per-slot broadcast valid      (registered)
//   cdb_rob_id_o   per-slot ROB id               (N_CDB x RW)
//   cdb_pd_o       per-slot physical dest        (N_CDB x PW)
//   cdb_data_o     per-slot result value         (N_CDB x 32)
//   stall_cnt_o    arbitration-loss counter (zero unless PERF_EN)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_CDB      = 2,
    parameter int ROB_DEPTH  = 8,
    parameter int PR_ENTRIES = 64,
    localparam int RW   = (ROB_DEPTH  > 1) ? $clog2(ROB_DEPTH)  : 1,
    localparam int PW   = (PR_ENTRIES > 1) ? $clog2(PR_ENTRIES) : 1,
    localparam int PTRW = (N_REQ      > 1) ? $clog2(N_REQ)      : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][RW-1:0]    req_rob_id_i,
    input  logic [N_REQ-1:0][PW-1:0]    req_pd_i,
    input  logic [N_REQ-1:0][31:0]      req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_CDB-1:0]            cdb_valid_o,
    output logic [N_CDB-1:0][RW-1:0]    cdb_rob_id_o,
    output logic [N_CDB-1:0][PW-1:0]    cdb_pd_o,
    output logic [N_CDB-1:0][31:0]      cdb_data_o,
    output logic [31:0]                 stall_cnt_o
);

    logic [PTRW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]           grant;
    logic [N_CDB-1:0]           cdb_valid_q, cdb_valid_d;
    logic [N_CDB-1:0][RW-1:0]   cdb_rob_id_q, cdb_rob_id_d;
    logic [N_CDB-1:0][PW-1:0]   cdb_pd_q, cdb_pd_d;
    logic [N_CDB-1:0][31:0]     cdb_data_q, cdb_data_d;

    // Walk the requesters in rotated order starting at rr_ptr. Each winner is
    // steered into the next free slot. The nested constant loops avoid
    // variable indexing so the selection flattens into plain muxes. Slot
    // payloads default to their held values so idle slots keep stale data.
    always_comb begin : arbitrate
        int n_granted;
        int idx;
        grant        = '0;
        rr_ptr_d     = rr_ptr_q;
        cdb_valid_d  = '0;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_pd_d     = cdb_pd_q;
        cdb_data_d   = cdb_data_q;
        n_granted    = 0;
        idx          = 0;
        if (!flush_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if ((i == idx) && req_valid_i[i] && (n_granted < N_CDB)) begin
                        grant[i] = 1'b1;
                        for (int j = 0; j < N_CDB; j++) begin
                            if (j == n_granted) begin
                                cdb_valid_d[j]  = 1'b1;
                                cdb_rob_id_d[j] = req_rob_id_i[i];
                                cdb_pd_d[j]     = req_pd_i[i];
                                cdb_data_d[j]   = req_data_i[i];
                            end
                        end
                        n_granted = n_granted + 1;
                        rr_ptr_d  = PTRW'((i + 1) % N_REQ);
                    end
                end
            end
        end
    end

    // While reset is held no requester may see a handshake, even though the
    // grant logic itself only looks at valid, pointer and flush.
    assign req_ready_o = grant & {N_REQ{rst_ni}};

    // Broadcast registers and round-robin pointer. Asserting reset wipes any
    // result captured for broadcast at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            cdb_valid_q  <= '0;
            cdb_rob_id_q <= '0;
            cdb_pd_q     <= '0;
            cdb_data_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_pd_q     <= cdb_pd_d;
            cdb_data_q   <= cdb_data_d;
        end
    end

    assign cdb_valid_o  = cdb_valid_q;
    assign cdb_rob_id_o = cdb_rob_id_q;
    assign cdb_pd_o     = cdb_pd_q;
    assign cdb_data_o   = cdb_data_q;

`ifdef CDB_ARBITER_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        lost;

    // A cycle counts as lost when some valid requester went ungranted. Flush
    // cycles are excluded because nobody can win then. The count saturates
    // rather than wrapping.
    always_comb begin
        lost        = !flush_i && ((req_valid_i & ~grant) != '0);
        stall_cnt_d = stall_cnt_q;
        if (lost && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter with N_REQ=4, N_CDB=2. Expected CDB
// contents are pushed to a scoreboard queue in the grant cycle. They are
// popped and compared one cycle later, when the DUT registers them. Directed
// scenarios use hand-derived constants. The random scenario uses a small
// behavioural round-robin model.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int N_REQ = 4;
    localparam int N_CDB = 2;
    localparam int RW    = 3;
    localparam int PW    = 6;
`ifdef CDB_ARBITER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                        clk_i = 1'b0;
    logic                        rst_ni = 1'b0;
    logic                        flush_i = 1'b0;
    logic [N_REQ-1:0]            req_valid_i = '0;
    logic [N_REQ-1:0][RW-1:0]    req_rob_id_i;
    logic [N_REQ-1:0][PW-1:0]    req_pd_i;
    logic [N_REQ-1:0][31:0]      req_data_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [N_CDB-1:0]            cdb_valid_o;
    logic [N_CDB-1:0][RW-1:0]    cdb_rob_id_o;
    logic [N_CDB-1:0][PW-1:0]    cdb_pd_o;
    logic [N_CDB-1:0][31:0]      cdb_data_o;
    logic [31:0]                 stall_cnt_o;

    typedef struct packed {
        logic [N_CDB-1:0]         v;
        logic [N_CDB-1:0][RW-1:0] rob;
        logic [N_CDB-1:0][PW-1:0] pd;
        logic [N_CDB-1:0][31:0]   data;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          m_rr;
    exp_t        m_hold;
    logic [31:0] m_stall;

    cdb_arbiter #(.N_REQ(4), .N_CDB(2), .ROB_DEPTH(8), .PR_ENTRIES(64)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_rob_id_i (req_rob_id_i),
        .req_pd_i     (req_pd_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .cdb_valid_o  (cdb_valid_o),
        .cdb_rob_id_o (cdb_rob_id_o),
        .cdb_pd_o     (cdb_pd_o),
        .cdb_data_o   (cdb_data_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Default directed payload of requester i; index 9 is the special
    // (5, 9, DEADBEEF) result and a negative index means the reset value.
    function automatic logic [RW+PW+31:0] pay(int i);
        if (i < 0) return '0;
        if (i == 9) return {3'd5, 6'd9, 32'hDEAD_BEEF};
        return {RW'(i + 1), PW'(i * 8), 32'hC0DE_0000 | 32'(i)};
    endfunction

    function automatic exp_t ex(logic [1:0] v, int a, int b);
        exp_t e;
        e.v = v;
        {e.rob[0], e.pd[0], e.data[0]} = pay(a);
        {e.rob[1], e.pd[1], e.data[1]} = pay(b);
        return e;
    endfunction

    task automatic set_payload();
        for (int i = 0; i < N_REQ; i++) begin
            {req_rob_id_i[i], req_pd_i[i], req_data_i[i]} = pay(i);
        end
    endtask

    task automatic apply_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        flush_i     = 1'b0;
        set_payload();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sbq.delete();
        m_rr    = 0;
        m_hold  = '0;
        m_stall = '0;
    endtask

    // Behavioural round-robin: scan from m_rr and take the first N_CDB
    // valid requesters. Push the expected next-cycle CDB state.
    task automatic model_step(output logic [N_REQ-1:0] rdy);
        exp_t e;
        int   n;
        int   idx;
        e   = m_hold;
        e.v = '0;
        rdy = '0;
        n   = 0;
        if (!flush_i) begin
            idx = m_rr;
            for (int k = 0; k < N_REQ; k++) begin
                if (req_valid_i[idx] && n < N_CDB) begin
                    rdy[idx]  = 1'b1;
                    e.v[n]    = 1'b1;
                    e.rob[n]  = req_rob_id_i[idx];
                    e.pd[n]   = req_pd_i[idx];
                    e.data[n] = req_data_i[idx];
                    n++;
                    m_rr = (idx + 1) % N_REQ;
                end
                idx = (idx + 1) % N_REQ;
            end
            if (((req_valid_i & ~rdy) != '0) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        end
        m_hold = e;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t got;
        rst_ni      = 1'b0;
        req_valid_i = 4'b1111;
        #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset.ready got %b want 0000", req_ready_o);
        end
        vectors++;
        if (got !== exp_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL reset.cdb got %h want 0", got);
        end
        vectors++;
        if (stall_cnt_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset.stall got %0d want 0", stall_cnt_o);
        end
        @(posedge clk_i); #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (got !== exp_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL reset.cdb_held got %h want 0", got);
        end
        req_valid_i = '0;
        rst_ni      = 1'b1;
    endtask

    task automatic test_all_valid();
        logic [N_REQ-1:0] vin[4] = '{4'b1111, 4'b1111, 4'b0011, 4'b0000};
        logic [N_REQ-1:0] rdy[4] = '{4'b0011, 4'b1100, 4'b0011, 4'b0000};
        exp_t ev[4];
        exp_t e, got;
        ev[0] = ex(2'b11, 0, 1); ev[1] = ex(2'b11, 2, 3);
        ev[2] = ex(2'b11, 0, 1); ev[3] = ex(2'b00, 0, 1);
        for (int c = 0; c < 4; c++) begin
            req_valid_i = vin[c];
            flush_i     = 1'b0;
            @(negedge clk_i);
            vectors++;
            if (req_ready_o !== rdy[c]) begin
                miscompares++;
                $display("[TB] FAIL all_valid.ready[%0d] got %b want %b", c, req_ready_o, rdy[c]);
            end
            sbq.push_back(ev[c]);
            @(posedge clk_i); #1;
            e   = sbq.pop_front();
            got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL all_valid.cdb[%0d] got %h want %h", c, got, e);
            end
        end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] vin[2] = '{4'b0100, 4'b0000};
        logic [N_REQ-1:0] rdy[2] = '{4'b0100, 4'b0000};
        exp_t ev[2];
        exp_t e, got;
        ev[0] = ex(2'b01, 9, -1); ev[1] = ex(2'b00, 9, -1);
        {req_rob_id_i[2], req_pd_i[2], req_data_i[2]} = pay(9);
        for (int c = 0; c < 2; c++) begin
            req_valid_i = vin[c];
            @(negedge clk_i);
            vectors++;
            if (req_ready_o !== rdy[c]) begin
                miscompares++;
                $display("[TB] FAIL single.ready[%0d] got %b want %b", c, req_ready_o, rdy[c]);
            end
            sbq.push_back(ev[c]);
            @(posedge clk_i); #1;
            e   = sbq.pop_front();
            got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL single.cdb[%0d] got %h want %h", c, got, e);
            end
        end
        set_payload();
    endtask

    task automatic test_wrap();
        logic [N_REQ-1:0] vin[2] = '{4'b1001, 4'b1111};
        logic [N_REQ-1:0] rdy[2] = '{4'b1001, 4'b0110};
        exp_t ev[2];
        exp_t e, got;
        ev[0] = ex(2'b11, 3, 0); ev[1] = ex(2'b11, 1, 2);
        for (int c = 0; c < 2; c++) begin
            req_valid_i = vin[c];
            @(negedge clk_i);
            vectors++;
            if (req_ready_o !== rdy[c]) begin
                miscompares++;
                $display("[TB] FAIL wrap.ready[%0d] got %b want %b", c, req_ready_o, rdy[c]);
            end
            sbq.push_back(ev[c]);
            @(posedge clk_i); #1;
            e   = sbq.pop_front();
            got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL wrap.cdb[%0d] got %h want %h", c, got, e);
            end
        end
    endtask

    task automatic test_flush();
        logic             fl[3]  = '{1'b0, 1'b1, 1'b0};
        logic [N_REQ-1:0] rdy[3] = '{4'b1001, 4'b0000, 4'b0110};
        exp_t ev[3];
        exp_t e, got;
        ev[0] = ex(2'b11, 3, 0); ev[1] = ex(2'b00, 3, 0); ev[2] = ex(2'b11, 1, 2);
        for (int c = 0; c < 3; c++) begin
            req_valid_i = 4'b1111;
            flush_i     = fl[c];
            @(negedge clk_i);
            vectors++;
            if (req_ready_o !== rdy[c]) begin
                miscompares++;
                $display("[TB] FAIL flush.ready[%0d] got %b want %b", c, req_ready_o, rdy[c]);
            end
            sbq.push_back(ev[c]);
            @(posedge clk_i); #1;
            e   = sbq.pop_front();
            got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL flush.cdb[%0d] got %h want %h", c, got, e);
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t got;
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        vectors++;
        if (req_ready_o !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.ready_pre got %b want 1001", req_ready_o);
        end
        @(posedge clk_i); #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (got !== ex(2'b11, 3, 0)) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.cdb_pre got %h want %h", got, ex(2'b11, 3, 0));
        end
        #2 rst_ni = 1'b0;
        #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (got !== exp_t'('0) || req_ready_o !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.immediate got cdb=%h ready=%b want 0/0000", got, req_ready_o);
        end
        @(posedge clk_i); #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (got !== exp_t'('0)) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.no_broadcast got %h want 0", got);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (req_ready_o !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.scan_from_0 got %b want 0011", req_ready_o);
        end
        @(posedge clk_i); #1;
        got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
        vectors++;
        if (got !== ex(2'b11, 0, 1)) begin
            miscompares++;
            $display("[TB] FAIL rst_mid.cdb_post got %h want %h", got, ex(2'b11, 0, 1));
        end
        req_valid_i = '0;
    endtask

    task automatic test_stall();
        logic             fl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [N_REQ-1:0] vin[5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic [N_REQ-1:0] rdy[5] = '{4'b0011, 4'b1100, 4'b0011, 4'b0000, 4'b0000};
        logic [31:0]      exp_stall;
        apply_reset();
        exp_stall = PERF ? 32'd3 : 32'd0;
        for (int c = 0; c < 5; c++) begin
            req_valid_i = vin[c];
            flush_i     = fl[c];
            @(negedge clk_i);
            vectors++;
            if (req_ready_o !== rdy[c]) begin
                miscompares++;
                $display("[TB] FAIL stall.ready[%0d] got %b want %b", c, req_ready_o, rdy[c]);
            end
            @(posedge clk_i); #1;
            if (c >= 2) begin
                vectors++;
                if (stall_cnt_o !== exp_stall) begin
                    miscompares++;
                    $display("[TB] FAIL stall.count[%0d] got %0d want %0d", c, stall_cnt_o, exp_stall);
                end
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] rdy;
        logic [N_REQ-1:0] dut_rdy;
        exp_t             e, got;
        logic [31:0]      exp_stall;
        int               waitc[N_REQ];
        apply_reset();
        foreach (waitc[i]) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid_i[i] && ($urandom_range(1, 0) == 1)) begin
                    req_valid_i[i]  = 1'b1;
                    req_rob_id_i[i] = RW'($urandom);
                    req_pd_i[i]     = ($urandom_range(3, 0) == 0) ? '0 : PW'($urandom);
                    req_data_i[i]   = $urandom;
                end
            end
            flush_i = ($urandom_range(15, 0) == 0);
            @(negedge clk_i);
            dut_rdy = req_ready_o;
            model_step(rdy);
            vectors++;
            if (dut_rdy !== rdy) begin
                miscompares++;
                $display("[TB] FAIL random.ready cyc %0d got %b want %b", c, dut_rdy, rdy);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid_i[i] && !flush_i) begin
                    waitc[i]++;
                    if (dut_rdy[i]) begin
                        vectors++;
                        if (waitc[i] > 2) begin
                            miscompares++;
                            $display("[TB] FAIL random.starve req %0d waited %0d want <=2", i, waitc[i]);
                        end
                        waitc[i] = 0;
                    end
                end
            end
            @(posedge clk_i); #1;
            e   = sbq.pop_front();
            got = {cdb_valid_o, cdb_rob_id_o, cdb_pd_o, cdb_data_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("[TB] FAIL random.cdb cyc %0d got %h want %h", c, got, e);
            end
            exp_stall = PERF ? m_stall : 32'd0;
            vectors++;
            if (stall_cnt_o !== exp_stall) begin
                miscompares++;
                $display("[TB] FAIL random.stall cyc %0d got %0d want %0d", c, stall_cnt_o, exp_stall);
            end
            req_valid_i = req_valid_i & ~dut_rdy;
        end
        req_valid_i = '0;
        flush_i     = 1'b0;
    endtask

    initial begin
        set_payload();
        apply_reset();
        test_all_valid();
        test_reset();
        test_single();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1);
    end

endmodule
